spi_baud_generator: RTL and testbench
=====================================

Name: spi_baud_generator

Overview:
- Serial-clock stage directly downstream of the APB register interface in the SPI master/slave core.
- Consumes SPPR/SPR, CPOL/CPHA, MSTR, SPISWAI, the SPI mode and the transfer-in-progress strobe.
- Produces the SCLK pin drive, plus one-cycle-early sample/shift flags that the shift-register stage uses to move bits.
- Also frames one 8-bit transfer (16 SCLK edges) and reports completion.

Parameters:
DIV_WIDTH, 12, width of the baud divisor and counter (max divisor 2048 needs 12 bits)
EDGES_PER_BYTE, 16, SCLK edges per transfer (8 bits x 2)

Ports:
PCLK  input  1  system clock; all state updates on its rising edge
PRESET_n  input  1  asynchronous active-low reset
mstr_i  input  1  1 = master; generator only runs in master mode
cpol_i  input  1  SCLK idle level
cpha_i  input  1  0 = sample on leading edge, 1 = sample on trailing edge
spiswai_i  input  1  stop SCLK in wait mode
spi_mode_i  input  2  00 run, 01 wait, 10 stop
sppr_i  input  3  baud preselection
spr_i  input  3  baud selection
ss_i  input  1  slave select, active low
tip_i  input  1  transfer request/in-progress from the shifter
sclk_o  output  1  serial clock
sample_flag_o  output  1  one-cycle pulse: the next PCLK edge is a sample edge
shift_flag_o  output  1  one-cycle pulse: the next PCLK edge is a shift edge
done_o  output  1  one-cycle pulse when the 16th edge completes
baud_div_o  output  DIV_WIDTH  current BaudRateDivisor

Behaviour:
- Divisor and half-period
  - baud_div_o = (sppr_i+1) * 2^(spr_i+1). Combinational, zero-extended to DIV_WIDTH.
  - Range is 2 (sppr=0, spr=0) to 2048 (sppr=7, spr=7).
  - half = baud_div_o >> 1.
- Enable
  - en = mstr_i & !ss_i & (spi_mode_i==00 | (spi_mode_i==01 & !spiswai_i)).
- States: IDLE, RUN, HOLD.
  - IDLE:
    - cnt=0, edge_cnt=0, sclk_o=cpol_i, flags low.
    - Go to RUN when tip_i & en.
  - RUN:
    - cnt increments each PCLK cycle.
    - When cnt==half-1: cnt<=0, sclk_o toggles, edge_cnt increments.
    - If en drops: go to HOLD.
    - If tip_i drops: go to IDLE immediately (abort).
  - HOLD:
    - cnt, sclk_o and edge_cnt are frozen.
    - Return to RUN when en returns; go to IDLE if tip_i drops.
- Edge flags
  - Combinational, asserted only in RUN when cnt==half-1. They lead the edge by one PCLK cycle.
  - The leading edge is the one with edge_cnt even.
  - cpha_i=0: sample_flag_o on leading edges, shift_flag_o on trailing edges.
  - cpha_i=1: the reverse.
  - Exactly one of the two flags is high per edge; neither is high otherwise.
- Completion
  - The toggle that makes edge_cnt==EDGES_PER_BYTE:
    - sets done_o high in the following cycle (registered, one cycle wide);
    - returns the FSM to IDLE with sclk_o equal to cpol_i.
  - done_o is not asserted on an abort.
- Divisor of 2 (half=1): toggle every PCLK cycle, flags high on every RUN cycle.
- Changes to sppr/spr/cpol/cpha mid-transfer are not supported. The new divisor takes effect at the next comparison.
- tip_i and en rising in the same cycle as completion: stay in IDLE for one cycle, restart the next cycle.
- Reset values: sclk_o=0, sample_flag_o=0, shift_flag_o=0, done_o=0, state IDLE, cnt=0, edge_cnt=0.
  - After reset release, sclk_o follows cpol_i in IDLE from the first clock.
- Reset mid-transfer: all state clears asynchronously. No done_o pulse.

Optional Feature:
- Macro: SPI_BAUD_SS_DRIVE_EN.
- Defined:
  - Adds output ss_o (1 bit), registered, reset 1.
  - ss_o is 0 from the cycle RUN is entered until the cycle done_o is asserted or an abort occurs, and 1 otherwise.
  - In this build, the enable term ignores ss_i whenever mstr_i=1.
- Undefined: no ss_o port; en uses ss_i as specified above.

Decomposition:
- Shared SPI package holds:
  - spi_mode encodings (SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10), the same values used by the register interface;
  - FSM state encodings (IDLE, RUN, HOLD);
  - DIV_WIDTH and EDGES_PER_BYTE defaults.
- One natural sub-module: spi_baud_div_calc, a combinational sppr/spr-to-divisor function, reusable by the slave-side edge detector.

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, mstr=1, ss=0, run mode, tip pulsed high and held -> sclk toggles every PCLK cycle; 8 sample flags alternate with 8 shift flags; done_o pulses 16 cycles after RUN entry; sclk returns to 0.
- sppr=2, spr=1 (div=12, half=6), cpol=1, cpha=1 -> first toggle 6 cycles after RUN entry, with shift_flag_o high in the preceding cycle; sclk idles at 1 before and after; baud_div_o=12.
- Mid-transfer, spi_mode=01 with spiswai=1 for 20 cycles, then back to 00 -> sclk and edge_cnt frozen in HOLD; exactly 16 edges in total; done_o pulses once.
- Drop tip_i after 5 edges -> state returns to IDLE next cycle; sclk=cpol; no done_o; edge_cnt=0 on restart.
- Assert PRESET_n low mid-RUN with cpol=1 -> sclk_o=0 and flags low immediately; after release, sclk_o=1 in IDLE.
- sppr=7, spr=7 -> baud_div_o=2048; one half-period is exactly 1024 PCLK cycles.

Source files
------------

// File: rtl/spi_baud_generator_pkg.sv
// Shared SPI definitions: spi_mode encodings, baud FSM states and sizing defaults.
// Used by the register interface, the baud generator and the slave-side edge detector.
package spi_baud_generator_pkg;

  localparam int DIV_WIDTH_DEF      = 12;
  localparam int EDGES_PER_BYTE_DEF = 16;

  typedef enum logic [1:0] {
    SPI_RUN  = 2'b00,
    SPI_WAIT = 2'b01,
    SPI_STOP = 2'b10
  } spi_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } baud_state_e;

  // SCLK may run in RUN mode, or in WAIT mode when SPISWAI does not stop it.
  function automatic logic mode_allows_sclk(input logic [1:0] spi_mode, input logic spiswai);
    return (spi_mode == SPI_RUN) || ((spi_mode == SPI_WAIT) && !spiswai);
  endfunction

endpackage

// File: rtl/spi_baud_generator_if.sv
// Bundle between the register/shifter side (master modport) and the baud generator (slave modport).
// SPI_BAUD_SS_DRIVE_EN adds the generator-driven ss_o signal.
interface spi_baud_generator_if #(
  parameter int DIV_WIDTH      = spi_baud_generator_pkg::DIV_WIDTH_DEF,
  parameter int EDGES_PER_BYTE = spi_baud_generator_pkg::EDGES_PER_BYTE_DEF
) ();
  import spi_baud_generator_pkg::*;

  localparam int EDGE_W = $clog2(EDGES_PER_BYTE + 1);

  logic                 mstr_i;
  logic                 cpol_i;
  logic                 cpha_i;
  logic                 spiswai_i;
  logic [1:0]           spi_mode_i;
  logic [2:0]           sppr_i;
  logic [2:0]           spr_i;
  logic                 ss_i;
  logic                 tip_i;
  logic                 sclk_o;
  logic                 sample_flag_o;
  logic                 shift_flag_o;
  logic                 done_o;
  logic [DIV_WIDTH-1:0] baud_div_o;
  // Debug view of the FSM and edge counter.
  baud_state_e          state_o;
  logic [EDGE_W-1:0]    edge_cnt_o;
`ifdef SPI_BAUD_SS_DRIVE_EN
  logic                 ss_o;
`endif

  // Handshake: tip_i is a level request held by the shifter for the whole
  // transfer; done_o is a one-cycle completion pulse, no back-pressure.
  modport slave (
    input  mstr_i, cpol_i, cpha_i, spiswai_i, spi_mode_i, sppr_i, spr_i, ss_i, tip_i,
`ifdef SPI_BAUD_SS_DRIVE_EN
    output ss_o,
`endif
    output sclk_o, sample_flag_o, shift_flag_o, done_o, baud_div_o, state_o, edge_cnt_o
  );

  modport master (
    output mstr_i, cpol_i, cpha_i, spiswai_i, spi_mode_i, sppr_i, spr_i, ss_i, tip_i,
`ifdef SPI_BAUD_SS_DRIVE_EN
    input  ss_o,
`endif
    input  sclk_o, sample_flag_o, shift_flag_o, done_o, baud_div_o, state_o, edge_cnt_o
  );

endinterface

// File: rtl/spi_baud_generator_div_calc.sv
// BaudRateDivisor = (SPPR+1) * 2^(SPR+1); purely combinational so the
// slave-side edge detector can reuse it.
module spi_baud_div_calc #(
  parameter int DIV_WIDTH = 12
) (
  input  logic [2:0]           sppr_i,
  input  logic [2:0]           spr_i,
  output logic [DIV_WIDTH-1:0] baud_div_o
);

  logic [DIV_WIDTH-1:0] presel;
  logic [3:0]           shamt;

  // spr+1 reaches 8, so the shift amount needs a fourth bit.
  assign presel     = DIV_WIDTH'({1'b0, sppr_i}) + DIV_WIDTH'(1);
  assign shamt      = {1'b0, spr_i} + 4'd1;
  assign baud_div_o = presel << shamt;

endmodule

// File: rtl/spi_baud_generator.sv
// Master-mode SCLK generator: divides PCLK, frames 16 SCLK edges per byte and
// gives the shifter one-cycle-early sample/shift flags. SPI_BAUD_SS_DRIVE_EN adds ss_o.
module spi_baud_generator
  import spi_baud_generator_pkg::*;
#(
  parameter int DIV_WIDTH      = DIV_WIDTH_DEF,
  parameter int EDGES_PER_BYTE = EDGES_PER_BYTE_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESET_n,
  spi_baud_generator_if.slave  bus
);

  localparam int EDGE_W = $clog2(EDGES_PER_BYTE + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES_PER_BYTE - 1);

  baud_state_e          state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [EDGE_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] baud_div;
  logic [DIV_WIDTH-1:0] half_m1;
  logic                 en;
  logic                 tick;
  logic                 leading;

  spi_baud_div_calc #(.DIV_WIDTH(DIV_WIDTH)) u_div_calc (
    .sppr_i     (bus.sppr_i),
    .spr_i      (bus.spr_i),
    .baud_div_o (baud_div)
  );

  assign half_m1 = (baud_div >> 1) - DIV_WIDTH'(1);

  // With the ss drive feature the generator owns slave select, so ss_i is
  // ignored while in master mode (and en is 0 outside master mode anyway).
`ifdef SPI_BAUD_SS_DRIVE_EN
  assign en = bus.mstr_i & (bus.mstr_i | ~bus.ss_i) & mode_allows_sclk(bus.spi_mode_i, bus.spiswai_i);
`else
  assign en = bus.mstr_i & ~bus.ss_i & mode_allows_sclk(bus.spi_mode_i, bus.spiswai_i);
`endif

  assign tick    = (state_q == ST_RUN) && (cnt_q == half_m1);
  assign leading = ~edge_cnt_q[0];

  // State register
`ifdef SPI_BAUD_SS_DRIVE_EN
  logic ss_q;
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) ss_q <= 1'b1;
    else           ss_q <= (state_d == ST_IDLE);
  end
  assign bus.ss_o = ss_q;
`endif

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. In RUN the divider advances even in the cycle en
  // drops, so a flag that was shown is always followed by its edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        edge_cnt_d = '0;
        sclk_d     = bus.cpol_i;
        if (bus.tip_i && en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.tip_i) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          edge_cnt_d = '0;
          sclk_d     = bus.cpol_i;
        end else begin
          if (tick) begin
            cnt_d      = '0;
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
          if (tick && (edge_cnt_q == LAST_EDGE)) begin
            state_d    = ST_IDLE;
            edge_cnt_d = '0;
            done_d     = 1'b1;
          end else if (!en) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.tip_i) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          edge_cnt_d = '0;
          sclk_d     = bus.cpol_i;
        end else if (en) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: leading edges (even edge_cnt) sample when CPHA=0, shift when CPHA=1.
  always_comb begin
    bus.sample_flag_o = 1'b0;
    bus.shift_flag_o  = 1'b0;
    if (tick) begin
      bus.sample_flag_o = leading ^ bus.cpha_i;
      bus.shift_flag_o  = ~(leading ^ bus.cpha_i);
    end
  end

  assign bus.sclk_o     = sclk_q;
  assign bus.done_o     = done_q;
  assign bus.baud_div_o = baud_div;
  assign bus.state_o    = state_q;
  assign bus.edge_cnt_o = edge_cnt_q;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: divisor table, full transfers,
// hold, abort, back-to-back restart, reset mid-transfer and the maximum divisor.
module tb_spi_baud_generator;
  import spi_baud_generator_pkg::*;

  logic PCLK;
  logic PRESET_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_baud_generator_if bif ();

  spi_baud_generator dut (
    .PCLK     (PCLK),
    .PRESET_n (PRESET_n),
    .bus      (bif)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [2:0] pp, input logic [2:0] rr, input logic pol, input logic pha);
    bif.sppr_i = pp;
    bif.spr_i  = rr;
    bif.cpol_i = pol;
    bif.cpha_i = pha;
  endtask

  task automatic test_reset;
    PRESET_n       = 1'b0;
    bif.mstr_i     = 1'b1;
    bif.ss_i       = 1'b0;
    bif.spiswai_i  = 1'b0;
    bif.spi_mode_i = SPI_RUN;
    bif.tip_i      = 1'b0;
    set_cfg(3'd0, 3'd0, 1'b1, 1'b0);
    #22;
    n_checks++; if (bif.sclk_o !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", bif.sclk_o); end
    n_checks++; if ({bif.sample_flag_o, bif.shift_flag_o, bif.done_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bif.sample_flag_o, bif.shift_flag_o, bif.done_o}); end
    n_checks++; if (bif.state_o !== ST_IDLE || bif.edge_cnt_o !== 5'd0) begin n_fail++; $display("FAIL reset_state: got state %0d edges %0d expected 0 0", bif.state_o, bif.edge_cnt_o); end
    @(negedge PCLK);
    PRESET_n = 1'b1;
    @(negedge PCLK);
    n_checks++; if (bif.sclk_o !== 1'b1) begin n_fail++; $display("FAIL reset_cpol_follow: got %b expected 1", bif.sclk_o); end
    bif.cpol_i = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_div_table;
    logic [2:0]  pp [6] = '{3'd0, 3'd7, 3'd2, 3'd1, 3'd5, 3'd3};
    logic [2:0]  rr [6] = '{3'd0, 3'd7, 3'd1, 3'd3, 3'd2, 3'd6};
    logic [11:0] ex [6] = '{12'd2, 12'd2048, 12'd12, 12'd32, 12'd48, 12'd512};
    for (int i = 0; i < 6; i++) begin
      bif.sppr_i = pp[i];
      bif.spr_i  = rr[i];
      #1;
      n_checks++; if (bif.baud_div_o !== ex[i]) begin n_fail++; $display("FAIL div_table[%0d]: got %0d expected %0d", i, bif.baud_div_o, ex[i]); end
    end
    @(negedge PCLK);
  endtask

  // Divisor 2: one edge per PCLK cycle, flags on every RUN cycle.
  task automatic test_div2_transfer;
    int   n_samp = 0;
    int   n_shift = 0;
    logic es;
    set_cfg(3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge PCLK);
    bif.tip_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge PCLK);
      if (bif.sample_flag_o === 1'b1) n_samp++;
      if (bif.shift_flag_o === 1'b1) n_shift++;
      if (k <= 16) begin
        es = ((k - 1) % 2 == 0);
        n_checks++; if (bif.sclk_o !== logic'((k - 1) % 2)) begin n_fail++; $display("FAIL div2_sclk k=%0d: got %b expected %0d", k, bif.sclk_o, (k - 1) % 2); end
        n_checks++; if (bif.sample_flag_o !== es || bif.shift_flag_o !== !es) begin n_fail++; $display("FAIL div2_flags k=%0d: got %b%b expected %b%b", k, bif.sample_flag_o, bif.shift_flag_o, es, !es); end
        n_checks++; if (bif.done_o !== 1'b0) begin n_fail++; $display("FAIL div2_early_done k=%0d: got %b expected 0", k, bif.done_o); end
`ifdef SPI_BAUD_SS_DRIVE_EN
        if (k == 1) begin n_checks++; if (bif.ss_o !== 1'b0) begin n_fail++; $display("FAIL div2_ss_low: got %b expected 0", bif.ss_o); end end
`endif
      end else begin
        n_checks++; if (bif.done_o !== 1'b1) begin n_fail++; $display("FAIL div2_done: got %b expected 1", bif.done_o); end
        n_checks++; if (bif.sclk_o !== 1'b0 || bif.state_o !== ST_IDLE) begin n_fail++; $display("FAIL div2_end: got sclk %b state %0d expected 0 0", bif.sclk_o, bif.state_o); end
`ifdef SPI_BAUD_SS_DRIVE_EN
        n_checks++; if (bif.ss_o !== 1'b1) begin n_fail++; $display("FAIL div2_ss_high: got %b expected 1", bif.ss_o); end
`endif
      end
    end
    bif.tip_i = 1'b0;
    n_checks++; if (n_samp != 8 || n_shift != 8) begin n_fail++; $display("FAIL div2_flag_count: got %0d/%0d expected 8/8", n_samp, n_shift); end
    @(negedge PCLK);
    n_checks++; if (bif.done_o !== 1'b0 || bif.state_o !== ST_IDLE) begin n_fail++; $display("FAIL div2_done_width: got done %b state %0d expected 0 0", bif.done_o, bif.state_o); end
  endtask

  // Divisor 12, CPOL=1, CPHA=1: first edge is a leading one and is a shift edge.
  task automatic test_cpol1_cpha1;
    int done_k = -1;
    set_cfg(3'd2, 3'd1, 1'b1, 1'b1);
    @(negedge PCLK);
    n_checks++; if (bif.sclk_o !== 1'b1) begin n_fail++; $display("FAIL c11_idle: got %b expected 1", bif.sclk_o); end
    n_checks++; if (bif.baud_div_o !== 12'd12) begin n_fail++; $display("FAIL c11_div: got %0d expected 12", bif.baud_div_o); end
    bif.tip_i = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge PCLK);
      if (k <= 5) begin
        n_checks++; if ({bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o} !== 3'b100) begin n_fail++; $display("FAIL c11_pre k=%0d: got %b expected 100", k, {bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o}); end
      end else if (k == 6) begin
        n_checks++; if ({bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o} !== 3'b101) begin n_fail++; $display("FAIL c11_flag: got %b expected 101", {bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o}); end
      end else if (k == 7) begin
        n_checks++; if ({bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o} !== 3'b000) begin n_fail++; $display("FAIL c11_toggle: got %b expected 000", {bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o}); end
      end
      if (bif.done_o === 1'b1) begin
        done_k = k;
        bif.tip_i = 1'b0;
        break;
      end
    end
    n_checks++; if (done_k != 97) begin n_fail++; $display("FAIL c11_done_cycle: got %0d expected 97", done_k); end
    n_checks++; if (bif.sclk_o !== 1'b1) begin n_fail++; $display("FAIL c11_end_idle: got %b expected 1", bif.sclk_o); end
    @(negedge PCLK);
  endtask

  // WAIT mode with SPISWAI=1 mid-transfer freezes SCLK and the edge count.
  task automatic test_hold;
    int         edges = 0;
    int         dones = 0;
    int         frozen_bad = 0;
    logic       prev;
    logic       f_sclk;
    logic [4:0] f_edge;
    set_cfg(3'd1, 3'd0, 1'b0, 1'b0);
    @(negedge PCLK);
    prev = bif.sclk_o;
    bif.tip_i = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge PCLK);
      if (bif.sclk_o !== prev) edges++;
      prev = bif.sclk_o;
      if (bif.done_o === 1'b1) begin dones++; bif.tip_i = 1'b0; end
      if (k == 5) begin bif.spi_mode_i = SPI_WAIT; bif.spiswai_i = 1'b1; end
      if (k == 6) begin
        f_sclk = bif.sclk_o;
        f_edge = bif.edge_cnt_o;
        n_checks++; if (bif.state_o !== ST_HOLD) begin n_fail++; $display("FAIL hold_state: got %0d expected %0d", bif.state_o, ST_HOLD); end
      end
      if (k > 6 && k <= 26 && (bif.sclk_o !== f_sclk || bif.edge_cnt_o !== f_edge)) frozen_bad++;
      if (k == 26) begin bif.spi_mode_i = SPI_RUN; bif.spiswai_i = 1'b0; end
    end
    n_checks++; if (frozen_bad != 0) begin n_fail++; $display("FAIL hold_frozen: got %0d moving cycles expected 0", frozen_bad); end
    n_checks++; if (edges != 16) begin n_fail++; $display("FAIL hold_edges: got %0d expected 16", edges); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL hold_done_count: got %0d expected 1", dones); end
  endtask

  // tip_i held through completion: one IDLE cycle, then a fresh transfer.
  task automatic test_back_to_back;
    set_cfg(3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge PCLK);
    bif.tip_i = 1'b1;
    repeat (17) @(negedge PCLK);
    n_checks++; if (bif.done_o !== 1'b1 || bif.state_o !== ST_IDLE) begin n_fail++; $display("FAIL b2b_done: got done %b state %0d expected 1 0", bif.done_o, bif.state_o); end
    @(negedge PCLK);
    n_checks++; if (bif.state_o !== ST_RUN || bif.edge_cnt_o !== 5'd0 || bif.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got state %0d edges %0d done %b expected 1 0 0", bif.state_o, bif.edge_cnt_o, bif.done_o); end
    bif.tip_i = 1'b0;
    @(negedge PCLK);
    n_checks++; if (bif.state_o !== ST_IDLE || bif.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_abort: got state %0d done %b expected 0 0", bif.state_o, bif.done_o); end
  endtask

  // Dropping tip_i after 5 edges aborts without done_o.
  task automatic test_abort;
    int   edges = 0;
    int   dones = 0;
    logic prev;
    set_cfg(3'd1, 3'd0, 1'b1, 1'b0);
    @(negedge PCLK);
    prev = bif.sclk_o;
    bif.tip_i = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge PCLK);
      if (bif.sclk_o !== prev) edges++;
      prev = bif.sclk_o;
      if (edges == 5) begin bif.tip_i = 1'b0; break; end
    end
    n_checks++; if (edges != 5) begin n_fail++; $display("FAIL abort_reach: got %0d edges expected 5", edges); end
    @(negedge PCLK);
    n_checks++; if (bif.state_o !== ST_IDLE || bif.sclk_o !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got state %0d sclk %b expected 0 1", bif.state_o, bif.sclk_o); end
    for (int k = 0; k < 10; k++) begin
      if (bif.done_o === 1'b1) dones++;
      @(negedge PCLK);
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    bif.tip_i = 1'b1;
    @(negedge PCLK);
    n_checks++; if (bif.state_o !== ST_RUN || bif.edge_cnt_o !== 5'd0 || bif.sclk_o !== 1'b1) begin n_fail++; $display("FAIL abort_restart: got state %0d edges %0d sclk %b expected 1 0 1", bif.state_o, bif.edge_cnt_o, bif.sclk_o); end
    bif.tip_i = 1'b0;
    @(negedge PCLK);
  endtask

  // Asynchronous reset while a flag is up, CPOL=1.
  task automatic test_reset_mid;
    set_cfg(3'd1, 3'd0, 1'b1, 1'b0);
    @(negedge PCLK);
    bif.tip_i = 1'b1;
    repeat (8) @(negedge PCLK);
    n_checks++; if (bif.shift_flag_o !== 1'b1 || bif.state_o !== ST_RUN) begin n_fail++; $display("FAIL rmid_pre: got shift %b state %0d expected 1 1", bif.shift_flag_o, bif.state_o); end
    PRESET_n  = 1'b0;
    bif.tip_i = 1'b0;
    #1;
    n_checks++; if ({bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o, bif.done_o} !== 4'b0000) begin n_fail++; $display("FAIL rmid_async: got %b expected 0000", {bif.sclk_o, bif.sample_flag_o, bif.shift_flag_o, bif.done_o}); end
    n_checks++; if (bif.state_o !== ST_IDLE || bif.edge_cnt_o !== 5'd0) begin n_fail++; $display("FAIL rmid_state: got state %0d edges %0d expected 0 0", bif.state_o, bif.edge_cnt_o); end
    @(negedge PCLK);
    PRESET_n = 1'b1;
    @(negedge PCLK);
    n_checks++; if (bif.sclk_o !== 1'b1 || bif.done_o !== 1'b0) begin n_fail++; $display("FAIL rmid_release: got sclk %b done %b expected 1 0", bif.sclk_o, bif.done_o); end
  endtask

  // Divisor 2048: each half-period is 1024 PCLK cycles.
  task automatic test_max_div;
    int   k1 = -1;
    int   k2 = -1;
    logic prev;
    set_cfg(3'd7, 3'd7, 1'b0, 1'b0);
    @(negedge PCLK);
    n_checks++; if (bif.baud_div_o !== 12'd2048) begin n_fail++; $display("FAIL max_div: got %0d expected 2048", bif.baud_div_o); end
    prev = bif.sclk_o;
    bif.tip_i = 1'b1;
    for (int k = 1; k <= 2200; k++) begin
      @(negedge PCLK);
      if (bif.sclk_o !== prev) begin
        if (k1 < 0) k1 = k;
        else begin k2 = k; break; end
      end
      prev = bif.sclk_o;
    end
    n_checks++; if (k1 != 1025) begin n_fail++; $display("FAIL max_first_edge: got %0d expected 1025", k1); end
    n_checks++; if (k2 - k1 != 1024) begin n_fail++; $display("FAIL max_half_period: got %0d expected 1024", k2 - k1); end
    bif.tip_i = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_div_table();
    test_div2_transfer();
    test_cpol1_cpha1();
    test_hold();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_max_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
